// File: rtl/reg_file_mp.sv
// Multi-read-port, dual-write-port register file with an init/clear zero sweep.
// Reads are registered (latency 1); write port 0 wins address collisions.
module reg_file_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int BYPASS       = 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 clear,
  output logic                                 ready,
  input  logic [NUM_RD_PORTS-1:0]              rd_req,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_valid,
  input  logic                                 wr_req_0,
  input  logic [ADDR_WIDTH-1:0]                wr_addr_0,
  input  logic [DATA_WIDTH-1:0]                wr_data_0,
  input  logic                                 wr_req_1,
  input  logic [ADDR_WIDTH-1:0]                wr_addr_1,
  input  logic [DATA_WIDTH-1:0]                wr_data_1,
  output logic                                 dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Handshake: a read or write is accepted on any rising edge where ready=1
  // and the matching req bit is high; there is no back-pressure beyond ready.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_next;
  logic                    run;
  logic                    we0;
  logic                    we1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    case (state)
      INIT: begin
        sweep_cnt_next = sweep_cnt + 1'b1;
        if (&sweep_cnt) begin
          state_next     = RUN;
          sweep_cnt_next = '0;
        end
      end
      RUN: begin
        if (clear) begin
          state_next     = INIT;
          sweep_cnt_next = '0;
        end
      end
      default: begin
        state_next     = INIT;
        sweep_cnt_next = '0;
      end
    endcase
  end

  assign run       = (state == RUN);
  assign ready     = run;
  assign dbg_state = state;

  // Port 1 is suppressed on a collision so port 0's data is the one stored.
  assign we0 = run && wr_req_0;
  assign we1 = run && wr_req_1 && !(wr_req_0 && (wr_addr_0 == wr_addr_1));

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[sweep_cnt] <= '0;
    end else begin
      if (we1) mem[wr_addr_1] <= wr_data_1;
      if (we0) mem[wr_addr_0] <= wr_data_0;
    end
  end

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rnext;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign ra = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

    // Write-first forwarding: port 0 is checked last so it wins a double match.
    always_comb begin
      rnext = mem[ra];
      if (BYPASS != 0) begin
        if (we1 && (wr_addr_1 == ra)) rnext = wr_data_1;
        if (we0 && (wr_addr_0 == ra)) rnext = wr_data_0;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= run && rd_req[g];
        if (run && rd_req[g]) data_q <= rnext;
      end
    end

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign rd_valid[g]                         = valid_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: write-first and read-first instances driven in parallel,
// checked every cycle against an array model plus directed literal expectations.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clear;
  logic [1:0]  rd_req;
  logic [7:0]  rd_addr;
  logic        wr_req_0, wr_req_1;
  logic [3:0]  wr_addr_0, wr_addr_1;
  logic [31:0] wr_data_0, wr_data_1;

  logic        ready_b1, ready_b0, dbg_b1, dbg_b0;
  logic [63:0] rd_data_b1, rd_data_b0;
  logic [1:0]  rd_valid_b1, rd_valid_b0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD_PORTS(2), .BYPASS(1)) u_byp (
    .clk(clk), .resetn(resetn), .clear(clear), .ready(ready_b1),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_valid(rd_valid_b1),
    .wr_req_0(wr_req_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_req_1(wr_req_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .dbg_state(dbg_b1));

  reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD_PORTS(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .resetn(resetn), .clear(clear), .ready(ready_b0),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_valid(rd_valid_b0),
    .wr_req_0(wr_req_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_req_1(wr_req_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .dbg_state(dbg_b0));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: sweep counter, word array, and what each port must show after the edge.
  logic [31:0] m_mem [16];
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  logic [31:0] exp_d1 [2] = '{32'h0, 32'h0};
  logic [31:0] exp_d0 [2] = '{32'h0, 32'h0};
  logic [1:0]  exp_valid = 2'b00;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run = 1'b0;
      m_cnt = 0;
      exp_valid = 2'b00;
      for (int i = 0; i < 2; i++) begin
        exp_d1[i] = 32'h0;
        exp_d0[i] = 32'h0;
      end
    end else if (!m_run) begin
      m_mem[m_cnt] = 32'h0;
      exp_valid = 2'b00;
      if (m_cnt == 15) begin
        m_run = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rd_req[i]) begin
          exp_d0[i] = m_mem[rd_addr[i*4 +: 4]];
          if (wr_req_0 && wr_addr_0 == rd_addr[i*4 +: 4])      exp_d1[i] = wr_data_0;
          else if (wr_req_1 && wr_addr_1 == rd_addr[i*4 +: 4]) exp_d1[i] = wr_data_1;
          else                                                 exp_d1[i] = exp_d0[i];
        end
      end
      exp_valid = rd_req;
      if (wr_req_1) m_mem[wr_addr_1] = wr_data_1;
      if (wr_req_0) m_mem[wr_addr_0] = wr_data_0;
      if (clear) begin
        m_run = 1'b0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_b1", {63'h0, ready_b1}, {63'h0, m_run});
      check("ready_b0", {63'h0, ready_b0}, {63'h0, m_run});
      check("valid_b1", {62'h0, rd_valid_b1}, {62'h0, exp_valid});
      check("valid_b0", {62'h0, rd_valid_b0}, {62'h0, exp_valid});
      check("data_b1", rd_data_b1, {exp_d1[1], exp_d1[0]});
      check("data_b0", rd_data_b0, {exp_d0[1], exp_d0[0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; rd_req = 2'b00; rd_addr = 8'h00;
    wr_req_0 = 1'b0; wr_addr_0 = 4'h0; wr_data_0 = 32'h0;
    wr_req_1 = 1'b0; wr_addr_1 = 4'h0; wr_data_1 = 32'h0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_b1 && n < 40) begin
      step();
      n++;
    end
    check(name, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetn = 1'b0;
    #7;
    check("reset_data", rd_data_b1, 64'h0);
    check("reset_ready", {63'h0, ready_b1}, 64'h0);
    chk_en = 1'b1;
    resetn = 1'b1;
    wait_ready("init_sweep_edges");

    for (int a = 0; a < 16; a++) begin
      rd_req = 2'b11;
      rd_addr = {a[3:0], a[3:0]};
      step();
      check("sweep_zero", rd_data_b1, 64'h0);
      check("sweep_valid", {62'h0, rd_valid_b1}, 64'h3);
    end
    idle();

    wr_req_0 = 1'b1; wr_addr_0 = 4'd3; wr_data_0 = 32'hA5A5A5A5;
    step();
    idle();
    rd_req = 2'b11; rd_addr = 8'h33;
    step();
    idle();
    check("rd3_both", rd_data_b1, 64'hA5A5A5A5_A5A5A5A5);
    check("rd3_valid", {62'h0, rd_valid_b1}, 64'h3);

    wr_req_0 = 1'b1; wr_addr_0 = 4'd5; wr_data_0 = 32'h11;
    wr_req_1 = 1'b1; wr_addr_1 = 4'd5; wr_data_1 = 32'h22;
    step();
    wr_addr_0 = 4'd6; wr_data_0 = 32'h66;
    wr_addr_1 = 4'd7; wr_data_1 = 32'h77777777;
    step();
    idle();
    rd_req = 2'b11; rd_addr = 8'h65;
    step();
    check("collide_p0_wins", {32'h0, rd_data_b1[31:0]}, 64'h11);
    check("dual_wr_6", {32'h0, rd_data_b1[63:32]}, 64'h66);
    rd_req = 2'b01; rd_addr = 8'h07;
    step();
    idle();
    check("dual_wr_7", {32'h0, rd_data_b1[31:0]}, 64'h77777777);

    wr_req_0 = 1'b1; wr_addr_0 = 4'd9; wr_data_0 = 32'h10;
    step();
    wr_data_0 = 32'h77;
    rd_req = 2'b01; rd_addr = 8'h09;
    step();
    idle();
    check("bypass_on", {32'h0, rd_data_b1[31:0]}, 64'h77);
    check("bypass_off", {32'h0, rd_data_b0[31:0]}, 64'h10);

    wr_req_0 = 1'b1; wr_addr_0 = 4'd10; wr_data_0 = 32'hAAAA;
    wr_req_1 = 1'b1; wr_addr_1 = 4'd10; wr_data_1 = 32'hBBBB;
    rd_req = 2'b10; rd_addr = 8'hA0;
    step();
    idle();
    check("double_match", {32'h0, rd_data_b1[63:32]}, 64'hAAAA);

    wr_req_0 = 1'b1; wr_addr_0 = 4'd2; wr_data_0 = 32'h2222;
    step();
    clear = 1'b1; wr_data_0 = 32'h3333;
    step();
    idle();
    check("clear_drops_ready", {63'h0, ready_b1}, 64'h0);
    begin
      int n = 0;
      while (!ready_b1 && n < 40) begin
        idle();
        if (n == 5) begin
          clear = 1'b1; rd_req = 2'b11; rd_addr = 8'h42;
          wr_req_0 = 1'b1; wr_addr_0 = 4'd4; wr_data_0 = 32'hDEAD;
        end
        step();
        n++;
      end
      check("clear_sweep_edges", n, 16);
    end
    idle();
    rd_req = 2'b11; rd_addr = 8'h42;
    step();
    idle();
    check("post_clear_zero", rd_data_b1, 64'h0);

    for (int k = 0; k < 150; k++) begin
      rd_req = 2'($urandom_range(0, 3));
      rd_addr = 8'($urandom_range(0, 255));
      wr_req_0 = 1'($urandom_range(0, 1));
      wr_addr_0 = 4'($urandom_range(0, 15));
      wr_data_0 = $urandom;
      wr_req_1 = 1'($urandom_range(0, 1));
      wr_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr_0 : 4'($urandom_range(0, 15));
      wr_data_1 = $urandom;
      step();
    end
    idle();

    wr_req_0 = 1'b1; wr_addr_0 = 4'd6; wr_data_0 = 32'h5A5A;
    step();
    idle();
    rd_req = 2'b11; rd_addr = 8'h66;
    step();
    idle();
    clear = 1'b1;
    step();
    idle();
    repeat (7) step();
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_data", rd_data_b1, 64'h0);
    check("async_rst_valid", {62'h0, rd_valid_b1}, 64'h0);
    check("async_rst_ready", {63'h0, ready_b1}, 64'h0);
    step();
    resetn = 1'b1;
    wait_ready("rst_sweep_edges");
    rd_req = 2'b11; rd_addr = 8'h60;
    step();
    idle();
    check("rst_sweep_zero", rd_data_b1, 64'h0);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set DEPTH = 2^ADDR_WIDTH entries.
REQ-003 Parameter NUM_RD_PORTS, default 2, range 1..8, SHALL set the number of read ports.
REQ-004 Parameter BYPASS, default 1, SHALL select write-first (1) or read-first (0) same-cycle behaviour.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 clear  input  1  SHALL request a full-array zero sweep.
REQ-008 ready  output  1  SHALL be high only when the array accepts reads and writes.
REQ-009 rd_req  input  NUM_RD_PORTS  SHALL be the per-port read request, bit i for port i.
REQ-010 rd_addr  input  NUM_RD_PORTS*ADDR_WIDTH  SHALL carry port i's address in slice i.
REQ-011 rd_data  output  NUM_RD_PORTS*DATA_WIDTH  SHALL carry port i's registered read data in slice i.
REQ-012 rd_valid  output  NUM_RD_PORTS  SHALL flag port i's rd_data as new this cycle.
REQ-013 wr_req_0, wr_addr_0, wr_data_0  input  1/ADDR_WIDTH/DATA_WIDTH  SHALL be write port 0, the higher-priority port.
REQ-014 wr_req_1, wr_addr_1, wr_data_1  input  1/ADDR_WIDTH/DATA_WIDTH  SHALL be write port 1.

Function
REQ-015 The block SHALL have two states: INIT (sweeping) and RUN.
REQ-016 INIT SHALL write zero to entry sweep_cnt each cycle, sweep_cnt counting 0..DEPTH-1, and go to RUN after writing entry DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-017 ready SHALL be 1 in RUN and 0 in INIT; it rises in the cycle after the last sweep write.
REQ-018 In INIT, rd_req, wr_req_0 and wr_req_1 SHALL be ignored: no array write, no rd_valid, rd_data held.
REQ-019 clear sampled high in RUN SHALL move the state to INIT with sweep_cnt = 0 on the next edge; writes presented in that same cycle SHALL still commit before the sweep starts.
REQ-020 clear in INIT SHALL be ignored; it SHALL NOT restart the sweep.
REQ-021 In RUN, an accepted read (rd_req[i]=1) SHALL load rd_data slice i on the next edge and set rd_valid[i]=1 for exactly that following cycle; read latency is 1.
REQ-022 With rd_req[i]=0, rd_data slice i SHALL hold its previous value and rd_valid[i] SHALL be 0.
REQ-023 In RUN, wr_req_0 and wr_req_1 SHALL both commit on the same edge when their addresses differ.
REQ-024 When both write ports target the same address, only wr_data_0 SHALL be stored.
REQ-025 With BYPASS=1, a read whose address matches a same-cycle committing write SHALL return the write data, port-0 data taking priority on a double match.
REQ-026 With BYPASS=0, such a read SHALL return the pre-write contents.
REQ-027 Any number of read ports MAY use the same address in one cycle, and each SHALL return identical data.
REQ-028 The array SHALL be plain registers or distributed RAM, with no reset on the storage itself; clearing is done only by the sweep.

Reset
REQ-029 Asserting resetn low SHALL immediately force state=INIT, sweep_cnt=0, ready=0, rd_valid=0 and rd_data=0, regardless of the clock.
REQ-030 After resetn deasserts, the sweep SHALL start on the first rising edge, and ready SHALL rise DEPTH cycles later.
REQ-031 Asserting resetn mid-sweep or mid-operation SHALL abort the current activity and restart a full sweep.

Verification
REQ-032 Reset release, DEPTH=16 -> ready=0 for exactly 16 edges, then 1; reading every address then returns 0 with rd_valid one cycle after each request.
REQ-033 Write addr 3 = 0xA5A5A5A5 on port 0; next cycle read addr 3 on ports 0 and 1 -> both return 0xA5A5A5A5 with rd_valid=2'b11 one cycle later.
REQ-034 In one cycle, wr_0 addr 5 = 0x11 and wr_1 addr 5 = 0x22 -> a later read of addr 5 returns 0x11; wr_0 addr 6 and wr_1 addr 7 in one cycle -> both stored.
REQ-035 Same-cycle write addr 9 = 0x77 (old value 0x10) and read addr 9 -> returns 0x77 with BYPASS=1 and 0x10 with BYPASS=0.
REQ-036 clear pulse in RUN together with a write to addr 2 -> ready drops for 16 cycles and ignores reads/writes during the sweep; addr 2 then reads 0; clear re-pulsed during INIT does not extend the sweep.
REQ-037 resetn asserted at sweep_cnt=7 -> outputs zero immediately, and a full 16-cycle sweep follows release.
